// File: rtl/acc_exec_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : acc_exec_sequencer_pkg
// Description : Shared encodings for the accumulator execute sequencer:
//               command opcodes, arithmetic-unit selects, FSM states and
//               ZNCV flag bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package acc_exec_sequencer_pkg;

    // Command opcodes
    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_NEG  = 3'b011;
    localparam logic [2:0] OP_INC  = 3'b100;
    localparam logic [2:0] OP_ADC  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;

    // Arithmetic unit select encodings
    localparam logic [1:0] SEL_ADD = 2'b00;   // A + B + Cin
    localparam logic [1:0] SEL_SUB = 2'b01;   // A + ~B + Cin
    localparam logic [1:0] SEL_NEG = 2'b10;   // ~B + Cin
    localparam logic [1:0] SEL_INC = 2'b11;   // B + 1 + Cin

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXEC   = 2'd1,
        MUL_IT = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Flag vector bit positions, vector is {Z,N,C,V}
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage
`default_nettype wire

// File: rtl/acc_exec_sequencer_flag_gen.sv
`default_nettype none
// ============================================================================
// Module      : acc_flag_gen
// Description : Combinational ZNCV flag computation for the value about to be
//               written into the accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module acc_flag_gen
    import acc_exec_sequencer_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [2:0]   i_op,
    input  logic [N-1:0] i_acc,       // accumulator before the operation
    input  logic         i_data_msb,  // sign bit of the command operand
    input  logic [N-1:0] i_new_acc,   // value being written to the accumulator
    input  logic         i_cout,      // arithmetic unit carry-out
    input  logic         i_mul_c,     // accumulated multiply carry
    output logic [3:0]   o_flags
);

    localparam logic [N-1:0] c_most_neg = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0] c_most_pos = {1'b0, {(N-1){1'b1}}};

    // Z/N come from the new value; C/V depend on the operation class
    always_comb begin
        o_flags         = '0;
        o_flags[FLAG_Z] = (i_new_acc == '0);
        o_flags[FLAG_N] = i_new_acc[N-1];
        case (i_op)
            OP_ADD, OP_ADC: begin
                o_flags[FLAG_C] = i_cout;
                o_flags[FLAG_V] = (i_acc[N-1] == i_data_msb) && (i_new_acc[N-1] != i_acc[N-1]);
            end
            OP_SUB: begin
                o_flags[FLAG_C] = i_cout;   // 1 = no borrow
                o_flags[FLAG_V] = (i_acc[N-1] != i_data_msb) && (i_new_acc[N-1] != i_acc[N-1]);
            end
            OP_NEG: begin
                o_flags[FLAG_C] = i_cout;
                o_flags[FLAG_V] = (i_acc == c_most_neg);
            end
            OP_INC: begin
                o_flags[FLAG_C] = i_cout;
                o_flags[FLAG_V] = (i_acc == c_most_pos);
            end
            OP_MUL: begin
                o_flags[FLAG_C] = i_mul_c;
                o_flags[FLAG_V] = 1'b0;
            end
            default: begin
                // LOAD and CLR never carry or overflow
                o_flags[FLAG_C] = 1'b0;
                o_flags[FLAG_V] = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/acc_exec_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : acc_exec_sequencer
// Description : Execute stage ahead of an external combinational arithmetic
//               unit. Holds an N-bit accumulator and ZNCV flags, accepts one
//               command at a time, performs multiply by repeated addition and
//               returns the result over a valid/ready response channel.
// Revision    : 1.0 - initial release
// ============================================================================
module acc_exec_sequencer
    import acc_exec_sequencer_pkg::*;
#(
    parameter int N  = 8,
    parameter int CW = 8    // multiply iteration counter width, CW >= N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_op,
    input  logic [N-1:0] cmd_data,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_acc,
    output logic [3:0]   rsp_flags,
    output logic [1:0]   arith_sel,
    output logic         arith_cin,
    output logic [N-1:0] arith_a,
    output logic [N-1:0] arith_b,
    input  logic [N-1:0] arith_result,
    input  logic         arith_cout,
    output logic         busy
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [2:0]      r_op;
    logic [N-1:0]    r_data;
    logic [N-1:0]    r_acc;
    logic [3:0]      r_flags;
    logic [N-1:0]    r_mcand;
    logic [N-1:0]    r_partial;
    logic [CW-1:0]   r_count;
    logic            r_mul_c;

    logic            w_accept;
    logic            w_mul_start;
    logic            w_last_it;
    logic            w_mul_c;
    logic [N-1:0]    w_new_acc;
    logic [3:0]      w_flags;

    assign w_accept    = (r_state == IDLE) && cmd_valid;
    assign w_mul_start = (r_op == OP_MUL) && (r_data != '0);
    assign w_last_it   = (r_count == CW'(1));
    assign w_mul_c     = (r_state == MUL_IT) ? (r_mul_c | arith_cout) : 1'b0;

    assign rsp_acc   = r_acc;
    assign rsp_flags = r_flags;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus handshake and arithmetic-unit drive
    always_comb begin
        w_state_nxt = r_state;
        cmd_ready   = 1'b0;
        rsp_valid   = 1'b0;
        busy        = 1'b1;
        arith_sel   = SEL_ADD;
        arith_cin   = 1'b0;
        arith_a     = '0;
        arith_b     = '0;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    w_state_nxt = EXEC;
                end
            end
            EXEC: begin
                case (r_op)
                    OP_ADD: begin
                        arith_a = r_acc;
                        arith_b = r_data;
                    end
                    OP_ADC: begin
                        arith_a   = r_acc;
                        arith_b   = r_data;
                        arith_cin = r_flags[FLAG_C];
                    end
                    OP_SUB: begin
                        arith_sel = SEL_SUB;
                        arith_a   = r_acc;
                        arith_b   = r_data;
                        arith_cin = 1'b1;
                    end
                    OP_NEG: begin
                        arith_sel = SEL_NEG;
                        arith_b   = r_acc;
                        arith_cin = 1'b1;
                    end
                    OP_INC: begin
                        arith_sel = SEL_INC;
                        arith_b   = r_acc;
                    end
                    default: ;  // LOAD, CLR and MUL setup leave the unit idle
                endcase
                w_state_nxt = w_mul_start ? MUL_IT : RESP;
            end
            MUL_IT: begin
                arith_a = r_partial;
                arith_b = r_mcand;
                if (w_last_it) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Value that the accumulator takes when an operation completes
    always_comb begin
        w_new_acc = arith_result;
        if (r_state == EXEC) begin
            case (r_op)
                OP_LOAD: w_new_acc = r_data;
                OP_CLR:  w_new_acc = '0;
                OP_MUL:  w_new_acc = '0;   // only reached with a zero multiplier
                default: w_new_acc = arith_result;
            endcase
        end
    end

    acc_flag_gen #(
        .N (N)
    ) u_flag_gen (
        .i_op       (r_op),
        .i_acc      (r_acc),
        .i_data_msb (r_data[N-1]),
        .i_new_acc  (w_new_acc),
        .i_cout     (arith_cout),
        .i_mul_c    (w_mul_c),
        .o_flags    (w_flags)
    );

    // Command capture, accumulator/flag update and multiply iteration state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op      <= OP_LOAD;
            r_data    <= '0;
            r_acc     <= '0;
            r_flags   <= '0;
            r_mcand   <= '0;
            r_partial <= '0;
            r_count   <= '0;
            r_mul_c   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op   <= cmd_op;
                r_data <= cmd_data;
            end
            if (r_state == EXEC) begin
                if (w_mul_start) begin
                    r_mcand   <= r_acc;
                    r_count   <= CW'(r_data);
                    r_partial <= '0;
                    r_mul_c   <= 1'b0;
                end else begin
                    r_acc   <= w_new_acc;
                    r_flags <= w_flags;
                end
            end
            if (r_state == MUL_IT) begin
                r_partial <= arith_result;
                r_count   <= r_count - CW'(1);
                r_mul_c   <= w_mul_c;
                if (w_last_it) begin
                    r_acc   <= w_new_acc;
                    r_flags <= w_flags;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_acc_exec_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_acc_exec_sequencer
// Description : Directed self-checking bench for acc_exec_sequencer with a
//               behavioural model of the external arithmetic unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_acc_exec_sequencer;
    import acc_exec_sequencer_pkg::*;

    localparam int N  = 8;
    localparam int CW = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic [N-1:0] cmd_data;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_acc;
    logic [3:0]   rsp_flags;
    logic [1:0]   arith_sel;
    logic         arith_cin;
    logic [N-1:0] arith_a;
    logic [N-1:0] arith_b;
    logic [N-1:0] arith_result;
    logic         arith_cout;
    logic         busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    acc_exec_sequencer #(.N(N), .CW(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_data     (cmd_data),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_acc      (rsp_acc),
        .rsp_flags    (rsp_flags),
        .arith_sel    (arith_sel),
        .arith_cin    (arith_cin),
        .arith_a      (arith_a),
        .arith_b      (arith_b),
        .arith_result (arith_result),
        .arith_cout   (arith_cout),
        .busy         (busy)
    );

    // External arithmetic unit model
    logic [N:0] w_sum;
    always_comb begin
        case (arith_sel)
            2'b00:   w_sum = {1'b0, arith_a} + {1'b0, arith_b} + {{N{1'b0}}, arith_cin};
            2'b01:   w_sum = {1'b0, arith_a} + {1'b0, ~arith_b} + {{N{1'b0}}, arith_cin};
            2'b10:   w_sum = {1'b0, ~arith_b} + {{N{1'b0}}, arith_cin};
            default: w_sum = {1'b0, arith_b} + {{N{1'b0}}, 1'b1} + {{N{1'b0}}, arith_cin};
        endcase
    end
    assign arith_result = w_sum[N-1:0];
    assign arith_cout   = w_sum[N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one command, check latency from the accept edge, response and
    // optionally the arithmetic-unit drive on cycle ar_k after accept.
    task automatic do_cmd(input string tag, input logic [2:0] op, input logic [7:0] data,
                          input int exp_lat, input logic [7:0] exp_acc, input logic [3:0] exp_fl,
                          input int ar_k, input logic [1:0] e_sel, input logic [7:0] e_a,
                          input logic [7:0] e_b, input logic e_cin);
        int k;
        @(negedge clk);
        chk({tag, "_ready"}, cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == ar_k) begin
                chk({tag, "_sel"}, arith_sel, e_sel);
                chk({tag, "_a"},   arith_a,   e_a);
                chk({tag, "_b"},   arith_b,   e_b);
                chk({tag, "_cin"}, arith_cin, e_cin);
            end
        end while (!rsp_valid && k < 300);
        chk({tag, "_lat"},   k,         exp_lat);
        chk({tag, "_acc"},   rsp_acc,   exp_acc);
        chk({tag, "_flags"}, rsp_flags, exp_fl);
        chk({tag, "_busy"},  busy,      1);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic stale;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = OP_LOAD;
        cmd_data  = '0;
        rsp_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy",      busy,      0);
        chk("rst_acc",       rsp_acc,   0);
        chk("rst_flags",     rsp_flags, 0);
        chk("rst_arith_a",   arith_a,   0);
        chk("rst_arith_sel", arith_sel, 0);
        rst = 1'b0;

        // Signed overflow on ADD
        do_cmd("load7f", OP_LOAD, 8'h7F, 2, 8'h7F, 4'b0000, 0, 2'd0, 8'h00, 8'h00, 1'b0);
        do_cmd("add01",  OP_ADD,  8'h01, 2, 8'h80, 4'b0101, 1, 2'd0, 8'h7F, 8'h01, 1'b0);

        // Subtract, borrow, negate
        do_cmd("load05", OP_LOAD, 8'h05, 2, 8'h05, 4'b0000, 0, 2'd0, 8'h00, 8'h00, 1'b0);
        do_cmd("sub05",  OP_SUB,  8'h05, 2, 8'h00, 4'b1010, 1, 2'd1, 8'h05, 8'h05, 1'b1);
        do_cmd("sub01",  OP_SUB,  8'h01, 2, 8'hFF, 4'b0100, 0, 2'd0, 8'h00, 8'h00, 1'b0);
        do_cmd("negff",  OP_NEG,  8'h00, 2, 8'h01, 4'b0000, 1, 2'd2, 8'h00, 8'hFF, 1'b1);
        do_cmd("load80", OP_LOAD, 8'h80, 2, 8'h80, 4'b0100, 0, 2'd0, 8'h00, 8'h00, 1'b0);
        do_cmd("neg80",  OP_NEG,  8'h00, 2, 8'h80, 4'b0101, 0, 2'd0, 8'h00, 8'h00, 1'b0);

        // Multiply by repeated addition
        do_cmd("load0c", OP_LOAD, 8'h0C, 2,  8'h0C, 4'b0000, 0, 2'd0, 8'h00, 8'h00, 1'b0);
        do_cmd("mul0b",  OP_MUL,  8'h0B, 13, 8'h84, 4'b0100, 2, 2'd0, 8'h00, 8'h0C, 1'b0);
        do_cmd("load20", OP_LOAD, 8'h20, 2,  8'h20, 4'b0000, 0, 2'd0, 8'h00, 8'h00, 1'b0);
        do_cmd("mul10",  OP_MUL,  8'h10, 18, 8'h00, 4'b1010, 0, 2'd0, 8'h00, 8'h00, 1'b0);
        do_cmd("mul00",  OP_MUL,  8'h00, 2,  8'h00, 4'b1000, 0, 2'd0, 8'h00, 8'h00, 1'b0);

        // Carry chain, ADC, INC overflow and wrap
        do_cmd("loadff", OP_LOAD, 8'hFF, 2, 8'hFF, 4'b0100, 0, 2'd0, 8'h00, 8'h00, 1'b0);
        do_cmd("addwrap",OP_ADD,  8'h01, 2, 8'h00, 4'b1010, 0, 2'd0, 8'h00, 8'h00, 1'b0);
        do_cmd("adc00",  OP_ADC,  8'h00, 2, 8'h01, 4'b0000, 1, 2'd0, 8'h00, 8'h00, 1'b1);
        do_cmd("load7f2",OP_LOAD, 8'h7F, 2, 8'h7F, 4'b0000, 0, 2'd0, 8'h00, 8'h00, 1'b0);
        do_cmd("inc7f",  OP_INC,  8'h00, 2, 8'h80, 4'b0101, 1, 2'd3, 8'h00, 8'h7F, 1'b0);
        do_cmd("loadff2",OP_LOAD, 8'hFF, 2, 8'hFF, 4'b0100, 0, 2'd0, 8'h00, 8'h00, 1'b0);
        do_cmd("incff",  OP_INC,  8'h00, 2, 8'h00, 4'b1010, 0, 2'd0, 8'h00, 8'h00, 1'b0);
        do_cmd("load55", OP_LOAD, 8'h55, 2, 8'h55, 4'b0000, 0, 2'd0, 8'h00, 8'h00, 1'b0);
        do_cmd("clr",    OP_CLR,  8'h55, 2, 8'h00, 4'b1000, 0, 2'd0, 8'h00, 8'h00, 1'b0);

        // Response back-pressure with a command continuously offered
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = OP_LOAD;
        cmd_data  = 8'h3C;
        @(posedge clk);
        #1;
        cmd_op    = OP_ADD;
        cmd_data  = 8'h11;
        repeat (2) @(negedge clk);
        chk("bp_valid0", rsp_valid, 1);
        chk("bp_acc0",   rsp_acc,   8'h3C);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", rsp_valid, 1);
            chk("bp_hold_acc",   rsp_acc,   8'h3C);
            chk("bp_hold_flags", rsp_flags, 4'b0000);
            chk("bp_hold_ready", cmd_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("bp_bubble_ready", cmd_ready, 1);
        chk("bp_bubble_busy",  busy,      0);
        chk("bp_bubble_valid", rsp_valid, 0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("bp_next_valid", rsp_valid, 1);
        chk("bp_next_acc",   rsp_acc,   8'h4D);
        chk("bp_next_flags", rsp_flags, 4'b0000);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;

        // Asynchronous reset in the middle of a multiply
        do_cmd("load05r", OP_LOAD, 8'h05, 2, 8'h05, 4'b0000, 0, 2'd0, 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = OP_MUL;
        cmd_data  = 8'h20;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("mulrst_busy_before", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("mulrst_acc",   rsp_acc,   0);
        chk("mulrst_flags", rsp_flags, 0);
        chk("mulrst_valid", rsp_valid, 0);
        chk("mulrst_busy",  busy,      0);
        chk("mulrst_arith_b", arith_b, 0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_ready", cmd_ready, 1);
        chk("postrst_busy",  busy,      0);
        stale = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid) stale = 1'b1;
        end
        chk("postrst_no_stale", stale, 0);
        do_cmd("postrst_add", OP_ADD, 8'h5A, 2, 8'h5A, 4'b0000, 0, 2'd0, 8'h00, 8'h00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/acc_exec_sequencer.md
Name: acc_exec_sequencer

Overview:
- Sequential execute stage placed directly upstream of the combinational arithmetic unit.
- Accepts accumulator commands over a valid/ready handshake and holds an N-bit accumulator plus ZNCV flags.
- Drives the arithmetic unit's operand, select and carry inputs, then registers its result and carry-out.
- Provides multi-cycle multiply by repeated addition and returns a response over a valid/ready handshake.

Parameters:
N, 8, datapath width (accumulator, operands, arithmetic unit width)
CW, 8, iteration counter width for MUL; must be >= N

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset, asynchronous, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  block can accept a command
cmd_op  in  3  000 LOAD, 001 ADD, 010 SUB, 011 NEG, 100 INC, 101 ADC, 110 MUL, 111 CLR
cmd_data  in  N  operand
rsp_valid  out  1  result available
rsp_ready  in  1  consumer takes result
rsp_acc  out  N  accumulator value
rsp_flags  out  4  {Z,N,C,V}
arith_sel  out  2  arithmetic unit select
arith_cin  out  1  arithmetic unit carry-in
arith_a  out  N  arithmetic unit operand A
arith_b  out  N  arithmetic unit operand B
arith_result  in  N  arithmetic unit result (combinational, same cycle)
arith_cout  in  1  arithmetic unit carry-out
busy  out  1  high in any state other than IDLE

Behaviour:
- Arithmetic unit contract:
  - sel 00: A+B+Cin
  - sel 01: A+~B+Cin
  - sel 10: ~B+Cin
  - sel 11: B+1+Cin
  - All widths are N; cout is the carry out of bit N-1.
- Reset (async, active-high): state IDLE, acc=0, flags=0, rsp_valid=0, cmd_ready=1, count=0, partial=0. Arith outputs go to 0.
- FSM states and transitions:
  - IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch op/data and go to EXEC.
  - EXEC: one cycle. Drive arith inputs per op and register the result. Go to RESP, or to MUL_IT for MUL with data≠0.
  - MUL_IT: one addition per cycle until count reaches 0, then go to RESP.
  - RESP: hold rsp_valid=1 with rsp_acc/rsp_flags stable until rsp_ready, then go to IDLE. rsp_ready sampled while rsp_valid=0 is ignored.
- Op mapping (arith_sel, arith_a, arith_b, arith_cin):
  - ADD: 00, acc, data, 0
  - ADC: 00, acc, data, C flag
  - SUB: 01, acc, data, 1
  - NEG: 10, 0, acc, 1
  - INC: 11, 0, acc, 0
  - LOAD and CLR bypass the arithmetic unit; acc is set to data or 0.
- Flags:
  - Z = (acc==0).
  - N = acc[N-1].
  - C = arith_cout. For SUB, C=1 means no borrow.
  - V = signed overflow. ADD/ADC: operand signs equal and result sign differs. SUB: signs differ and result sign ≠ acc sign. NEG: V=1 iff acc==100..0. INC: V=1 iff acc==011..1.
  - LOAD/CLR: C=0, V=0.
- MUL semantics (acc ← acc*data mod 2^N):
  - EXEC latches multiplicand=acc, count=data, partial=0.
  - Each MUL_IT cycle: sel 00, A=partial, B=multiplicand, cin=0. Then partial←result and count←count-1.
  - C = OR of all iteration couts; V=0.
  - data=0: skip MUL_IT, acc=0, Z=1, C=0.
- Latency, measured from the accept edge: rsp_valid at +2 for non-MUL ops and for MUL with data=0; at +2+data for MUL.
- Exactly one command is in flight. cmd_ready is 0 from accept until the RESP handshake completes.
- Simultaneous rsp handshake and cmd_valid: no accept that cycle; accept occurs in the following IDLE cycle. This fixes a 1-cycle bubble.
- Reset mid-operation: abort immediately, return to reset values, drop any pending response.
- Width rule: all arithmetic wraps modulo 2^N. No saturation.

Decomposition:
- Shared package:
  - op encodings (OP_LOAD..OP_CLR)
  - arith select encodings (SEL_ADD=00, SEL_SUB=01, SEL_NEG=10, SEL_INC=11)
  - FSM state enum (IDLE, EXEC, MUL_IT, RESP)
  - flag bit indices (Z=3, N=2, C=1, V=0)
- One natural sub-module: acc_flag_gen, a combinational ZNCV computation from op, operands, result and cout.
- The arithmetic unit stays external and is connected at the parent level.

Test Plan:
- LOAD 0x7F, then ADD 0x01 → rsp_acc=0x80, flags Z0 N1 C0 V1, rsp_valid exactly 2 cycles after each accept.
- LOAD 0x05, SUB 0x05 → 0x00, Z1 C1. Then SUB 0x01 → 0xFF, N1 C0 V0. Then NEG → 0x01. Then LOAD 0x80, NEG → 0x80, V1.
- LOAD 0x0C, MUL 0x0B → 0x84, C0, rsp_valid at accept+13. LOAD 0x20, MUL 0x10 → 0x00, Z1 C1. MUL 0x00 → 0x00 at accept+2.
- LOAD 0xFF, ADD 0x01 → 0x00, C1. Then ADC 0x00 → 0x01, C0. Then INC at 0x7F → 0x80, V1.
- Hold rsp_ready=0 for 5 cycles with cmd_valid=1 and new ops → rsp_acc/flags stable, cmd_ready=0, no command accepted. The next accept happens one cycle after the rsp handshake.
- Assert rst for 1 cycle, asynchronously between clock edges, during MUL_IT of MUL 0x20 → acc=0, flags=0, rsp_valid=0, busy=0 immediately. No stale response after release; cmd_ready=1 on the first post-reset cycle.
